fetch_unit_q: RTL and testbench

Parametrised multi-wide instruction fetch unit with an in-order fetch queue.
- Issues aligned FETCH_WIDTH-instruction bundle requests to a synchronous instruction memory.
- Buffers the returned bundles in a FIFO and delivers them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/JALR target) with queue flush, in-flight kill and unaligned-target slot masking.
- Sits between the instruction memory and the decode/rename stage.

---
 rtl/fetch_unit_q.sv | 158 +++++++++++++++
 tb/tb_fetch_unit_q.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_q.sv
// fetch_unit_q: multi-wide instruction fetch unit with an in-order fetch queue.
//
// Issues aligned FETCH_WIDTH-instruction bundle requests to a synchronous
// instruction memory (data returns the cycle after the request). Returned
// bundles are buffered in a FIFO and handed to decode over valid/ready.
// A redirect flushes the queue, kills the in-flight response and restarts
// fetch at the aligned target, masking off slots before the target.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   redirect_valid   redirect fetch this cycle
//   redirect_pc      redirect target (bits [1:0] ignored)
//   imem_req         bundle request issued this cycle
//   imem_addr        bundle base address (FETCH_WIDTH*4 aligned)
//   imem_rdata       bundle data, valid the cycle after imem_req
//   out_valid        head bundle available
//   out_ready        consumer accepts head bundle
//   out_pc           base address of head bundle
//   out_inst         head bundle instructions, slot i = bits[32i+31:32i]
//   out_slot_mask    per-slot valid bits of head bundle
//   queue_count      occupied queue entries
module fetch_unit_q #(
    parameter int unsigned                 FETCH_WIDTH     = 2,
    parameter int unsigned                 INST_ADDR_WIDTH = 32,
    parameter int unsigned                 QUEUE_DEPTH     = 4,
    parameter logic [INST_ADDR_WIDTH-1:0]  RESET_PC        = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0]    redirect_pc,
    output logic                          imem_req,
    output logic [INST_ADDR_WIDTH-1:0]    imem_addr,
    input  logic [32*FETCH_WIDTH-1:0]     imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INST_ADDR_WIDTH-1:0]    out_pc,
    output logic [32*FETCH_WIDTH-1:0]     out_inst,
    output logic [FETCH_WIDTH-1:0]        out_slot_mask,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int unsigned AW    = INST_ADDR_WIDTH;
    localparam int unsigned DW    = 32 * FETCH_WIDTH;
    localparam int unsigned ALIGN = FETCH_WIDTH * 4;
    localparam int unsigned PW    = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned OW    = CW + 1;

    logic [AW-1:0]          fetch_pc_q, fetch_pc_d;
    logic [FETCH_WIDTH-1:0] first_mask_q, first_mask_d;
    logic                   pending_q;
    logic                   kill_q;
    logic [AW-1:0]          req_pc_q;
    logic [FETCH_WIDTH-1:0] req_mask_q;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic [AW-1:0]          pc_mem_q   [QUEUE_DEPTH];
    logic [DW-1:0]          inst_mem_q [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0] mask_mem_q [QUEUE_DEPTH];

    logic                   issue;
    logic                   enq;
    logic                   deq;
    logic [OW-1:0]          occupancy;
    logic [AW-1:0]          redir_slot;
    logic [FETCH_WIDTH-1:0] redir_mask;

    always_comb begin
        // Outstanding request is reserved a slot; this cycle's dequeue is not
        // credited, which keeps out_ready off the imem_req path.
        occupancy = {1'b0, count_q} + OW'(pending_q);
        issue     = !reset && !redirect_valid && (occupancy < OW'(QUEUE_DEPTH));
        deq       = (count_q != '0) && out_ready;
        // A redirect flushes at end of cycle, so a response landing now is dropped too.
        enq       = pending_q && !kill_q && !redirect_valid;

        // Slot index of the redirect target inside its bundle.
        redir_slot = (redirect_pc >> 2) & AW'(FETCH_WIDTH - 1);
        redir_mask = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            redir_mask[i] = (AW'(i) >= redir_slot);
        end

        fetch_pc_d   = fetch_pc_q;
        first_mask_d = first_mask_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc & ~AW'(ALIGN - 1);
            first_mask_d = redir_mask;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (issue) begin
                fetch_pc_d   = fetch_pc_q + AW'(ALIGN);
                first_mask_d = '1;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            first_mask_q <= '1;
            pending_q    <= 1'b0;
            kill_q       <= 1'b0;
            req_pc_q     <= RESET_PC;
            req_mask_q   <= '1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                mask_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            first_mask_q <= first_mask_d;
            pending_q    <= issue;
            kill_q       <= redirect_valid;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (issue) begin
                req_pc_q   <= fetch_pc_q;
                req_mask_q <= first_mask_q;
            end
            if (enq) begin
                pc_mem_q[wr_ptr_q]   <= req_pc_q;
                inst_mem_q[wr_ptr_q] <= imem_rdata;
                mask_mem_q[wr_ptr_q] <= req_mask_q;
            end
        end
    end

    assign imem_req      = issue;
    assign imem_addr     = fetch_pc_q;
    assign out_valid     = (count_q != '0);
    assign out_pc        = pc_mem_q[rd_ptr_q];
    assign out_inst      = inst_mem_q[rd_ptr_q];
    assign out_slot_mask = mask_mem_q[rd_ptr_q];
    assign queue_count   = count_q;

endmodule

// File: tb/tb_fetch_unit_q.sv
module tb_fetch_unit_q;

    localparam int FW = 2;
    localparam int AW = 32;
    localparam int QD = 4;
    localparam int CW = $clog2(QD) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic              imem_req;
    logic [AW-1:0]     imem_addr;
    logic [32*FW-1:0]  imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_pc;
    logic [32*FW-1:0]  out_inst;
    logic [FW-1:0]     out_slot_mask;
    logic [CW-1:0]     queue_count;

    fetch_unit_q #(
        .FETCH_WIDTH(FW),
        .INST_ADDR_WIDTH(AW),
        .QUEUE_DEPTH(QD),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .out_slot_mask(out_slot_mask),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]    pc;
        logic [32*FW-1:0] inst;
        logic [FW-1:0]    mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] bundle_of(logic [31:0] base);
        return {inst_of(base + 32'd4), inst_of(base)};
    endfunction

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    task automatic push_exp(logic [AW-1:0] pc, logic [FW-1:0] mask);
        exp_t e;
        e.pc   = pc;
        e.inst = bundle_of(pc);
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    // Synchronous instruction memory: data for a request appears next cycle.
    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= bundle_of(imem_addr);
    end

    // Monitor: every accepted head bundle must match the scoreboard front.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got pc %h expected none (t=%0t)", out_pc, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", 64'(out_pc), 64'(mon_e.pc));
                chk("out_inst", 64'(out_inst), 64'(mon_e.inst));
                chk("out_slot_mask", 64'(out_slot_mask), 64'(mon_e.mask));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("req_in_reset", 64'(imem_req), 64'd0);
        cyc();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(queue_count), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Phase 1: streaming with out_ready high.
        do_reset();
        cyc(); reset = 1'b0; out_ready = 1'b1;
        push_exp(32'h0, 2'b11);
        push_exp(32'h8, 2'b11);
        #1;
        chk("p1_req0", 64'(imem_req), 64'd1);
        chk("p1_addr0", 64'(imem_addr), 64'h0);
        chk("p1_valid0", 64'(out_valid), 64'd0);
        cyc(); #1;
        chk("p1_addr1", 64'(imem_addr), 64'h8);
        cyc(); #1;
        chk("p1_addr2", 64'(imem_addr), 64'h10);
        chk("p1_valid2", 64'(out_valid), 64'd1);
        chk("p1_count2", 64'(queue_count), 64'd1);
        cyc(); #1;
        chk("p1_addr3", 64'(imem_addr), 64'h18);
        chk("p1_count3", 64'(queue_count), 64'd1);
        cyc(); out_ready = 1'b0;

        // Phase 2: fill with out_ready low, single dequeue, then redirect with 0x20 in flight.
        do_reset();
        cyc(); reset = 1'b0; #1;
        chk("p2_addr0", 64'(imem_addr), 64'h0);
        cyc(); #1;
        chk("p2_addr1", 64'(imem_addr), 64'h8);
        cyc(); #1;
        chk("p2_addr2", 64'(imem_addr), 64'h10);
        cyc(); #1;
        chk("p2_addr3", 64'(imem_addr), 64'h18);
        chk("p2_req3", 64'(imem_req), 64'd1);
        cyc(); #1;
        chk("p2_req4_stall", 64'(imem_req), 64'd0);
        chk("p2_count4", 64'(queue_count), 64'd3);
        cyc(); #1;
        chk("p2_req5_stall", 64'(imem_req), 64'd0);
        chk("p2_count_full", 64'(queue_count), 64'd4);
        chk("p2_valid_full", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        push_exp(32'h0, 2'b11);
        cyc(); out_ready = 1'b0; #1;
        chk("p2_count_after_deq", 64'(queue_count), 64'd3);
        chk("p2_req_0x20", 64'(imem_req), 64'd1);
        chk("p2_addr_0x20", 64'(imem_addr), 64'h20);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h104; #1;
        chk("p2_req_on_redirect", 64'(imem_req), 64'd0);
        cyc(); redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        push_exp(32'h100, 2'b10);
        push_exp(32'h108, 2'b11);
        #1;
        chk("p2_valid_after_redirect", 64'(out_valid), 64'd0);
        chk("p2_count_after_redirect", 64'(queue_count), 64'd0);
        chk("p2_req_0x100", 64'(imem_req), 64'd1);
        chk("p2_addr_0x100", 64'(imem_addr), 64'h100);
        cyc(); #1;
        chk("p2_addr_0x108", 64'(imem_addr), 64'h108);
        chk("p2_no_stale_0x20", 64'(out_valid), 64'd0);
        cyc(); #1;
        chk("p2_valid_new", 64'(out_valid), 64'd1);
        chk("p2_count_new", 64'(queue_count), 64'd1);
        cyc(); #1;
        cyc(); out_ready = 1'b0;

        // Phase 3: full queue then continuous streaming; redirect coincides with a dequeue.
        do_reset();
        cyc(); reset = 1'b0; #1;
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
        end
        cyc(); #1;
        chk("p3_count_full", 64'(queue_count), 64'd4);
        out_ready = 1'b1;
        for (int k = 0; k <= 12; k++) push_exp(32'(8 * k), 2'b11);
        for (int k = 6; k <= 16; k++) begin
            cyc(); #1;
            chk("p3_stream_req", 64'(imem_req), 64'd1);
            chk("p3_stream_addr", 64'(imem_addr), 64'(32'h20 + 32'(8 * (k - 6))));
            if (k == 6) chk("p3_count_k6", 64'(queue_count), 64'd3);
            else        chk("p3_count_steady", 64'(queue_count), 64'd2);
        end
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
        chk("p3_req_on_redirect", 64'(imem_req), 64'd0);
        chk("p3_valid_on_redirect", 64'(out_valid), 64'd1);
        cyc(); redirect_valid = 1'b0;
        chk("p3_old_stream_delivered", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        push_exp(32'h200, 2'b11);
        push_exp(32'h208, 2'b11);
        #1;
        chk("p3_valid_after_redirect", 64'(out_valid), 64'd0);
        chk("p3_count_after_redirect", 64'(queue_count), 64'd0);
        chk("p3_addr_0x200", 64'(imem_addr), 64'h200);
        cyc(); #1;
        chk("p3_addr_0x208", 64'(imem_addr), 64'h208);
        cyc(); #1;
        chk("p3_valid_new", 64'(out_valid), 64'd1);
        cyc(); #1;
        cyc(); out_ready = 1'b0;

        // Phase 4: reset mid-stream with 3 entries plus one response in flight.
        do_reset();
        cyc(); reset = 1'b0; #1;
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
        end
        cyc(); #1;
        chk("p4_count3", 64'(queue_count), 64'd3);
        chk("p4_pending_stall", 64'(imem_req), 64'd0);
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        chk("p4_valid_after_reset", 64'(out_valid), 64'd0);
        chk("p4_count_after_reset", 64'(queue_count), 64'd0);
        chk("p4_req_after_reset", 64'(imem_req), 64'd1);
        chk("p4_addr_reset_pc", 64'(imem_addr), 64'h0);
        cyc(); #1;
        chk("p4_stale_dropped", 64'(queue_count), 64'd0);
        cyc(); out_ready = 1'b1;
        push_exp(32'h0, 2'b11);
        #1;
        chk("p4_count_first", 64'(queue_count), 64'd1);
        cyc(); out_ready = 1'b0;

        cyc(); cyc();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
